jt08_adpcmb_regs: RTL and testbench

CPU-facing register front-end for the ADPCM-B channel. It sits directly upstream of jt08_adpcm_drvB.
- Decodes CPU writes to the ADPCM-B register map (0x00–0x10) into the driver's static controls (acmd_*, alr_b, astart_b, aend_b, adeltan_b, aeg_b, alimit_b).
- Generates the driver's single-cycle command pulses and the driver's flag-clear strobes.
- Sequences the sel_ram/wr_n/rd_n handshake for data-port (0x08) accesses.
- Builds the status byte and IRQ from the driver's flag outputs.

---
 rtl/jt08_adpcmb_regs.sv | 256 +++++++++++++++++++++++++
 tb/tb_jt08_adpcmb_regs.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jt08_adpcmb_regs.sv
// CPU register front-end for the ADPCM-B driver: register decode, command pulses,
// data-port handshake sequencing, status byte and IRQ. Optional: JT08_ADPCMB_RDBACK_EN.
module jt08_adpcmb_regs #(
  parameter int HOLD_CEN = 6
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [4:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic [7:0]  drv_dout,
  output logic [7:0]  drv_din,
  output logic        sel_ram,
  output logic        wr_n,
  output logic        rd_n,
  output logic        data_busy,
  output logic        acmd_on_b,
  output logic        acmd_rep_b,
  output logic        acmd_mem_b,
  output logic        acmd_rec_b,
  output logic        acmd_x8_b,
  output logic        acmd_rom_b,
  output logic        acmd_rst_b,
  output logic        acmd_up_b,
  output logic [1:0]  alr_b,
  output logic [15:0] astart_b,
  output logic [15:0] aend_b,
  output logic [15:0] adeltan_b,
  output logic [15:0] alimit_b,
  output logic [7:0]  aeg_b,
  output logic [3:0]  clr_flag,
  input  logic [3:0]  flag,
  output logic        irq_n
);

  localparam int CW = $clog2(HOLD_CEN + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sel_ram_reg, sel_ram_next;
  logic          wr_n_reg, wr_n_next;
  logic          rd_n_reg, rd_n_next;
  logic          hold_done;
  logic [7:0]    drv_din_reg, rdbuf_reg;

  logic          on_reg, rec_reg, mem_reg, rep_reg, x8_reg, rom_reg;
  logic          rst_pulse_reg, up_pulse_reg;
  logic [1:0]    alr_reg;
  logic [15:0]   astart_reg, aend_reg, adeltan_reg, alimit_reg;
  logic [7:0]    aeg_reg;
  logic [3:0]    mask_reg, clr_flag_reg, flag_reg, flag_rise;
  logic          irq_n_reg, irq_clr;
  logic [7:0]    cpu_dout_reg, rd_data;

  logic          port_wr, port_rd;

  assign port_wr = cpu_wr && (cpu_addr == 5'h08);
  assign port_rd = cpu_rd && (cpu_addr == 5'h08) && !port_wr;
  assign irq_clr = cpu_wr && (cpu_addr == 5'h10) && cpu_din[7];

  // Register file and command pulses; writes do not wait for cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_reg        <= 1'b0;
      rec_reg       <= 1'b0;
      mem_reg       <= 1'b0;
      rep_reg       <= 1'b0;
      x8_reg        <= 1'b0;
      rom_reg       <= 1'b0;
      rst_pulse_reg <= 1'b0;
      up_pulse_reg  <= 1'b0;
      alr_reg       <= 2'b00;
      astart_reg    <= 16'h0000;
      aend_reg      <= 16'h0000;
      adeltan_reg   <= 16'h0000;
      alimit_reg    <= 16'h0000;
      aeg_reg       <= 8'h00;
      mask_reg      <= 4'h0;
      clr_flag_reg  <= 4'h0;
    end else begin
      clr_flag_reg <= 4'h0;
      // Pulses survive until the driver has seen them on one cen edge.
      if (rst_pulse_reg && cen) rst_pulse_reg <= 1'b0;
      if (up_pulse_reg && cen)  up_pulse_reg  <= 1'b0;
      if (cpu_wr) begin
        case (cpu_addr)
          5'h00: begin
            rec_reg <= cpu_din[6];
            mem_reg <= cpu_din[5];
            rep_reg <= cpu_din[4];
            if (cpu_din[0]) begin
              on_reg        <= 1'b0;
              rst_pulse_reg <= 1'b1;
            end else begin
              on_reg <= cpu_din[7];
              if (cpu_din[7] && !on_reg) up_pulse_reg <= 1'b1;
            end
          end
          5'h01: begin
            alr_reg <= cpu_din[7:6];
            x8_reg  <= cpu_din[1];
            rom_reg <= cpu_din[0];
          end
          5'h02: astart_reg[7:0]   <= cpu_din;
          5'h03: astart_reg[15:8]  <= cpu_din;
          5'h04: aend_reg[7:0]     <= cpu_din;
          5'h05: aend_reg[15:8]    <= cpu_din;
          5'h09: adeltan_reg[7:0]  <= cpu_din;
          5'h0A: adeltan_reg[15:8] <= cpu_din;
          5'h0B: aeg_reg           <= cpu_din;
          5'h0C: alimit_reg[7:0]   <= cpu_din;
          5'h0D: alimit_reg[15:8]  <= cpu_din;
          5'h10: begin
            if (cpu_din[7]) clr_flag_reg <= 4'hF;
            else            mask_reg     <= cpu_din[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Data-port FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_ram_reg <= 1'b0;
      wr_n_reg    <= 1'b1;
      rd_n_reg    <= 1'b1;
      drv_din_reg <= 8'h00;
      rdbuf_reg   <= 8'h00;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_ram_reg <= sel_ram_next;
      wr_n_reg    <= wr_n_next;
      rd_n_reg    <= rd_n_next;
      if (state_reg == IDLE && port_wr) drv_din_reg <= cpu_din;
      if (hold_done && !rd_n_reg)       rdbuf_reg   <= drv_dout;
    end
  end

  // Entry from IDLE is immediate; HOLD and RELEASE only move on cen.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sel_ram_next = sel_ram_reg;
    wr_n_next    = wr_n_reg;
    rd_n_next    = rd_n_reg;
    hold_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (port_wr || port_rd) begin
          state_next   = HOLD;
          cnt_next     = '0;
          sel_ram_next = 1'b1;
          wr_n_next    = ~port_wr;
          rd_n_next    = ~port_rd;
        end
      end
      HOLD: begin
        if (cen) begin
          if (cnt_reg == CW'(HOLD_CEN - 1)) begin
            hold_done    = 1'b1;
            state_next   = RELEASE;
            sel_ram_next = 1'b0;
            wr_n_next    = 1'b1;
            rd_n_next    = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (cen) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-bit rising edge of unmasked flags.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag_rise
      assign flag_rise[gi] = flag[gi] && !flag_reg[gi] && !mask_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg  <= 4'h0;
      irq_n_reg <= 1'b1;
    end else begin
      flag_reg <= flag;
      if (|flag_rise)   irq_n_reg <= 1'b0;
      else if (irq_clr) irq_n_reg <= 1'b1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (cpu_addr)
      5'h08: rd_data = rdbuf_reg;
      5'h1F: rd_data = {~irq_n_reg, 3'b000, flag};
`ifdef JT08_ADPCMB_RDBACK_EN
      5'h00: rd_data = {on_reg, rec_reg, mem_reg, rep_reg, 4'b0000};
      5'h01: rd_data = {alr_reg, 4'b0000, x8_reg, rom_reg};
      5'h02: rd_data = astart_reg[7:0];
      5'h03: rd_data = astart_reg[15:8];
      5'h04: rd_data = aend_reg[7:0];
      5'h05: rd_data = aend_reg[15:8];
      5'h09: rd_data = adeltan_reg[7:0];
      5'h0A: rd_data = adeltan_reg[15:8];
      5'h0B: rd_data = aeg_reg;
      5'h0C: rd_data = alimit_reg[7:0];
      5'h0D: rd_data = alimit_reg[15:8];
      5'h10: rd_data = {4'b0000, mask_reg};
`endif
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cpu_dout_reg <= 8'h00;
    else if (cpu_rd) cpu_dout_reg <= rd_data;
  end

  assign cpu_dout   = cpu_dout_reg;
  assign drv_din    = drv_din_reg;
  assign sel_ram    = sel_ram_reg;
  assign wr_n       = wr_n_reg;
  assign rd_n       = rd_n_reg;
  assign data_busy  = (state_reg != IDLE);
  assign acmd_on_b  = on_reg;
  assign acmd_rep_b = rep_reg;
  assign acmd_mem_b = mem_reg;
  assign acmd_rec_b = rec_reg;
  assign acmd_x8_b  = x8_reg;
  assign acmd_rom_b = rom_reg;
  assign acmd_rst_b = rst_pulse_reg;
  assign acmd_up_b  = up_pulse_reg;
  assign alr_b      = alr_reg;
  assign astart_b   = astart_reg;
  assign aend_b     = aend_reg;
  assign adeltan_b  = adeltan_reg;
  assign alimit_b   = alimit_reg;
  assign aeg_b      = aeg_reg;
  assign clr_flag   = clr_flag_reg;
  assign irq_n      = irq_n_reg;

endmodule

// File: tb/tb_jt08_adpcmb_regs.sv
// Directed bench for jt08_adpcmb_regs: command pulses, data port, status and IRQ.
module tb_jt08_adpcmb_regs;

  logic        rst_n, clk, cen;
  logic        cpu_wr, cpu_rd;
  logic [4:0]  cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic [7:0]  drv_dout, drv_din;
  logic        sel_ram, wr_n, rd_n, data_busy;
  logic        acmd_on_b, acmd_rep_b, acmd_mem_b, acmd_rec_b, acmd_x8_b, acmd_rom_b;
  logic        acmd_rst_b, acmd_up_b;
  logic [1:0]  alr_b;
  logic [15:0] astart_b, aend_b, adeltan_b, alimit_b;
  logic [7:0]  aeg_b;
  logic [3:0]  clr_flag, flag;
  logic        irq_n;

  int checks = 0;
  int failures = 0;

  jt08_adpcmb_regs #(.HOLD_CEN(6)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .drv_dout(drv_dout), .drv_din(drv_din),
    .sel_ram(sel_ram), .wr_n(wr_n), .rd_n(rd_n), .data_busy(data_busy),
    .acmd_on_b(acmd_on_b), .acmd_rep_b(acmd_rep_b), .acmd_mem_b(acmd_mem_b),
    .acmd_rec_b(acmd_rec_b), .acmd_x8_b(acmd_x8_b), .acmd_rom_b(acmd_rom_b),
    .acmd_rst_b(acmd_rst_b), .acmd_up_b(acmd_up_b),
    .alr_b(alr_b), .astart_b(astart_b), .aend_b(aend_b),
    .adeltan_b(adeltan_b), .alimit_b(alimit_b), .aeg_b(aeg_b),
    .clr_flag(clr_flag), .flag(flag), .irq_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cen high one clk in four
  logic [1:0] cen_div = 2'd0;
  always @(posedge clk) cen_div <= cen_div + 2'd1;
  assign cen = (cen_div == 2'd3);

  // Edge-sampled monitors: what the driver would see on cen edges
  int up_samp = 0, rst_samp = 0, sel_cen = 0;
  always @(posedge clk) begin
    if (acmd_up_b && cen)  up_samp  <= up_samp + 1;
    if (acmd_rst_b && cen) rst_samp <= rst_samp + 1;
    if (sel_ram && !wr_n && cen) sel_cen <= sel_cen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a);
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (data_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, data_busy}, 32'd0);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 5'h0;
    cpu_din = 8'h00; drv_dout = 8'h00; flag = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_sel_ram", {31'd0, sel_ram}, 32'd0);
    chk("rst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("rst_rd_n", {31'd0, rd_n}, 32'd1);
    chk("rst_irq_n", {31'd0, irq_n}, 32'd1);
    chk("rst_cpu_dout", {24'd0, cpu_dout}, 32'h00);
    chk("rst_busy", {31'd0, data_busy}, 32'd0);
    chk("rst_clr_flag", {28'd0, clr_flag}, 32'h0);

    // 1: start pulse, only on 0->1 of on
    base = up_samp;
    cpu_write(5'h00, 8'h80);
    chk("up_asserted", {31'd0, acmd_up_b}, 32'd1);
    chk("on_set", {31'd0, acmd_on_b}, 32'd1);
    repeat (10) @(negedge clk);
    chk("up_one_cen", up_samp - base, 32'd1);
    chk("up_dropped", {31'd0, acmd_up_b}, 32'd0);
    cpu_write(5'h00, 8'h80);
    repeat (10) @(negedge clk);
    chk("up_no_repeat", up_samp - base, 32'd1);
    chk("on_held", {31'd0, acmd_on_b}, 32'd1);

    // 2: reset pulse forces on low
    base = rst_samp;
    cpu_write(5'h00, 8'hA1);
    chk("rst_pulse", {31'd0, acmd_rst_b}, 32'd1);
    chk("rst_on_low", {31'd0, acmd_on_b}, 32'd0);
    chk("rst_mem", {31'd0, acmd_mem_b}, 32'd1);
    chk("rst_no_up", {31'd0, acmd_up_b}, 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_one_cen", rst_samp - base, 32'd1);

    // static registers
    cpu_write(5'h01, 8'hC3);
    chk("alr_x8_rom", {27'd0, alr_b, acmd_x8_b, acmd_rom_b, acmd_rec_b}, {27'd0, 2'b11, 1'b1, 1'b1, 1'b0});
    cpu_write(5'h02, 8'h34);
    cpu_write(5'h03, 8'h12);
    chk("astart", {16'd0, astart_b}, 32'h1234);
    cpu_write(5'h0D, 8'hBE);
    cpu_write(5'h0C, 8'hEF);
    chk("alimit", {16'd0, alimit_b}, 32'hBEEF);
    cpu_write(5'h0B, 8'h5C);
    chk("aeg", {24'd0, aeg_b}, 32'h5C);
    cpu_write(5'h07, 8'hFF);
    chk("unused_addr", {16'd0, aend_b}, 32'h0000);
    cpu_read(5'h02);
`ifdef JT08_ADPCMB_RDBACK_EN
    chk("rdback_02", {24'd0, cpu_dout}, 32'h34);
`else
    chk("rdback_02", {24'd0, cpu_dout}, 32'h00);
`endif

    // 3: data-port write, second access dropped
    base = sel_cen;
    cpu_write(5'h08, 8'h5A);
    chk("dw_drv_din", {24'd0, drv_din}, 32'h5A);
    chk("dw_sel", {30'd0, sel_ram, wr_n}, 32'b10);
    chk("dw_busy", {31'd0, data_busy}, 32'd1);
    cpu_write(5'h08, 8'hC3);
    chk("dw_drop", {24'd0, drv_din}, 32'h5A);
    wait_idle("dw_idle");
    chk("dw_hold_cen", sel_cen - base, 32'd6);
    chk("dw_release", {29'd0, sel_ram, wr_n, rd_n}, 32'b011);

    // 4: reads are one behind
    drv_dout = 8'h33;
    cpu_read(5'h08);
    chk("rd1", {24'd0, cpu_dout}, 32'h00);
    wait_idle("rd1_idle");
    drv_dout = 8'h77;
    cpu_read(5'h08);
    chk("rd2", {24'd0, cpu_dout}, 32'h33);
    wait_idle("rd2_idle");
    drv_dout = 8'h00;
    cpu_read(5'h08);
    chk("rd3", {24'd0, cpu_dout}, 32'h77);
    wait_idle("rd3_idle");

    // 5: IRQ set, clear, masked edge
    cpu_write(5'h10, 8'h0E);
    flag = 4'b0001;
    repeat (2) @(negedge clk);
    chk("irq_eos", {31'd0, irq_n}, 32'd0);
    cpu_read(5'h1F);
    chk("status_irq", {24'd0, cpu_dout}, 32'h81);
    cpu_write(5'h10, 8'h80);
    chk("clr_flag_on", {28'd0, clr_flag}, 32'hF);
    chk("irq_cleared", {31'd0, irq_n}, 32'd1);
    @(negedge clk);
    chk("clr_flag_off", {28'd0, clr_flag}, 32'h0);
    flag = 4'b0011;
    repeat (3) @(negedge clk);
    chk("irq_masked", {31'd0, irq_n}, 32'd1);
    cpu_read(5'h1F);
    chk("status_noirq", {24'd0, cpu_dout}, 32'h03);

    // 6: async reset mid-access
    cpu_write(5'h10, 8'h00);
    flag = 4'b0111;
    repeat (2) @(negedge clk);
    chk("irq_zero", {31'd0, irq_n}, 32'd0);
    cpu_read(5'h08);
    chk("pre_rst_sel", {30'd0, sel_ram, rd_n}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel", {31'd0, sel_ram}, 32'd0);
    chk("async_wr_rd", {30'd0, wr_n, rd_n}, 32'b11);
    chk("async_irq_n", {31'd0, irq_n}, 32'd1);
    chk("async_astart", {16'd0, astart_b}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
